spi_slave_frame: RTL and testbench

- Parametrised successor to the Mode-0-only SPI slave.
- Receives one CMD|ADDR|PAYLOAD frame per chip-select window in any SPI mode (CPOL/CPHA), field widths configurable.
- Returns a full-width response frame on miso, loaded through a valid/ready handshake.
- Sits between the external SPI master pins and the LED command decoder, in the sysclk domain.

---
 rtl/spi_slave_frame.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_frame.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// SPI slave for one CMD|ADDR|PAYLOAD frame per chip-select window, any CPOL/CPHA mode.
// A response frame is buffered through a valid/ready handshake and shifted out on miso.
module spi_slave_frame #(
  parameter int unsigned CMD_BITS     = 8,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned CPOL         = 0,
  parameter int unsigned CPHA         = 0,
  parameter int unsigned SYNC_STAGES  = 2,
  localparam int unsigned FRAME_W     = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
  localparam int unsigned CNT_W       = $clog2(FRAME_W + 1)
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic [FRAME_W-1:0]      tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [CMD_BITS-1:0]     o_cmd,
  output logic [ADDR_BITS-1:0]    o_addr,
  output logic [PAYLOAD_BITS-1:0] o_payload,
  output logic                    rx_valid,
  output logic                    rx_abort,
  output logic                    tx_underrun
);

  localparam logic SclkIdle   = (CPOL != 0);
  localparam logic LateSample = (CPHA != 0);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StHold} state_e;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;

  state_e             state_q;
  logic [FRAME_W-1:0] rx_shift_q;
  logic [FRAME_W-1:0] tx_shift_q;
  logic [FRAME_W-1:0] tx_buf_q;
  logic               tx_full_q;
  logic [CNT_W-1:0]   bit_cnt_q;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_high, mosi_bit;

  // cs_s resets low so a reset inside an active window never sees a fresh falling edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sclk_s <= {SYNC_STAGES{SclkIdle}};
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_rise   = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
  assign sclk_fall   = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
  assign lead_edge   = SclkIdle ? sclk_fall : sclk_rise;
  assign trail_edge  = SclkIdle ? sclk_rise : sclk_fall;
  assign sample_edge = LateSample ? trail_edge : lead_edge;
  assign shift_edge  = LateSample ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s[SYNC_STAGES-2] & cs_s[SYNC_STAGES-1];
  assign cs_high     = cs_s[SYNC_STAGES-2];
  // One stage older than the sclk edge view, so data is settled when the edge is seen.
  assign mosi_bit    = mosi_s[SYNC_STAGES-1];

  assign tx_ready = rst_n && !tx_full_q && (state_q == StIdle);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      bit_cnt_q   <= '0;
      o_cmd       <= '0;
      o_addr      <= '0;
      o_payload   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;

      if (tx_valid && tx_ready) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (cs_fall) begin
            state_q    <= StShift;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_oe    <= 1'b1;
            // A handshake in this same cycle cannot reach this frame; it stays buffered.
            if (tx_full_q) begin
              tx_shift_q <= tx_buf_q;
              miso       <= tx_buf_q[FRAME_W-1];
              tx_full_q  <= 1'b0;
            end else begin
              tx_shift_q  <= '0;
              tx_underrun <= 1'b1;
            end
          end
        end
        StShift: begin
          if (bit_cnt_q == CNT_W'(FRAME_W)) begin
            state_q <= StDone;
          end else if (cs_high) begin
            state_q  <= StIdle;
            rx_abort <= 1'b1;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[FRAME_W-2:0], mosi_bit};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
            end
            // With late sampling the MSB is already on miso before the first shift edge.
            if (shift_edge && !(LateSample && bit_cnt_q == '0)) begin
              tx_shift_q <= tx_shift_q << 1;
              miso       <= tx_shift_q[FRAME_W-2];
            end
          end
        end
        StDone: begin
          o_cmd     <= rx_shift_q[FRAME_W-1 -: CMD_BITS];
          o_addr    <= rx_shift_q[FRAME_W-CMD_BITS-1 -: ADDR_BITS];
          o_payload <= rx_shift_q[PAYLOAD_BITS-1:0];
          rx_valid  <= 1'b1;
          miso      <= 1'b0;
          state_q   <= StHold;
        end
        StHold: begin
          miso <= 1'b0;
          if (cs_high) begin
            state_q <= StIdle;
          end
        end
      endcase

      if (cs_high) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: four default-width instances (modes 0-3) and one 4/4/16 instance,
// driven by a bit-level SPI master and checked against a frame-level reference model.
module tb_spi_slave_frame;

  localparam int HALF = 8;

  logic        sysclk = 1'b0;
  logic        rst_n, sclk, mosi;
  logic [4:0]  cs_n, tx_valid;
  logic [23:0] tx_data;
  logic [4:0]  miso, miso_oe, tx_ready, rx_valid, rx_abort, tx_underrun;
  logic [7:0]  cmd_m [4];
  logic [7:0]  addr_m[4];
  logic [7:0]  pay_m [4];
  logic [3:0]  p_cmd, p_addr;
  logic [15:0] p_pay;

  always #4 sysclk = ~sysclk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_frame #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n[g]), .mosi(mosi),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .o_cmd(cmd_m[g]), .o_addr(addr_m[g]), .o_payload(pay_m[g]),
      .rx_valid(rx_valid[g]), .rx_abort(rx_abort[g]), .tx_underrun(tx_underrun[g])
    );
  end

  spi_slave_frame #(.CMD_BITS(4), .ADDR_BITS(4), .PAYLOAD_BITS(16)) u_dut_p (
    .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n[4]), .mosi(mosi),
    .miso(miso[4]), .miso_oe(miso_oe[4]), .tx_data(tx_data), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .o_cmd(p_cmd), .o_addr(p_addr), .o_payload(p_pay),
    .rx_valid(rx_valid[4]), .rx_abort(rx_abort[4]), .tx_underrun(tx_underrun[4])
  );

  // Pulse counters: each counts cycles the strobe is high, so a stretched pulse shows up.
  int n_valid[5] = '{default: 0};
  int n_abort[5] = '{default: 0};
  int n_under[5] = '{default: 0};

  always @(posedge sysclk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid[i])    n_valid[i] <= n_valid[i] + 1;
      if (rx_abort[i])    n_abort[i] <= n_abort[i] + 1;
      if (tx_underrun[i]) n_under[i] <= n_under[i] + 1;
    end
  end

  // Reference model: last completed frame per instance and the response buffer.
  logic [23:0] last_rx [5];
  logic        buf_full[5];
  logic [23:0] buf_val [5];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  function automatic logic [31:0] obs_field(input int idx, input int f);
    if (idx < 4) begin
      case (f)
        0:       return 32'(cmd_m[idx]);
        1:       return 32'(addr_m[idx]);
        default: return 32'(pay_m[idx]);
      endcase
    end else begin
      case (f)
        0:       return 32'(p_cmd);
        1:       return 32'(p_addr);
        default: return 32'(p_pay);
      endcase
    end
  endfunction

  function automatic logic [31:0] exp_field(input int idx, input int f);
    int aw, pw;
    logic [31:0] fr;
    fr = 32'(last_rx[idx]);
    aw = (idx < 4) ? 8 : 4;
    pw = (idx < 4) ? 8 : 16;
    case (f)
      0:       return fr >> (aw + pw);
      1:       return (fr >> pw) & ((32'd1 << aw) - 1);
      default: return fr & ((32'd1 << pw) - 1);
    endcase
  endfunction

  task automatic check_fields(input string tag, input int idx);
    for (int f = 0; f < 3; f++)
      check($sformatf("%s_i%0d_f%0d", tag, idx, f), obs_field(idx, f), exp_field(idx, f));
  endtask

  task automatic load_tx(input int idx, input logic [23:0] d);
    int k;
    k = 0;
    while (!tx_ready[idx] && k < 50) begin
      @(negedge sysclk);
      k++;
    end
    check($sformatf("tx_ready_wait_i%0d", idx), 32'(tx_ready[idx]), 1);
    tx_data       = d;
    tx_valid[idx] = 1'b1;
    @(negedge sysclk);
    tx_valid[idx] = 1'b0;
    buf_full[idx] = 1'b1;
    buf_val[idx]  = d;
    check($sformatf("tx_ready_full_i%0d", idx), 32'(tx_ready[idx]), 0);
  endtask

  // Bit-level master. With do_rst, rst_n pulses after nbits bits and the rest of the
  // 24 bits are clocked into a slave that must ignore them.
  task automatic xfer(input int idx, input logic [23:0] frame, input int nbits, input int extra,
                      input bit do_rst, output logic [23:0] got);
    int cpol, cpha, total;
    logic b;
    cpol  = (idx < 4) ? idx / 2 : 0;
    cpha  = (idx < 4) ? idx % 2 : 0;
    total = do_rst ? 24 : nbits;
    got   = '0;
    sclk  = (cpol != 0);
    wait_cyc(4);
    cs_n[idx] = 1'b0;
    wait_cyc(HALF);
    check($sformatf("miso_oe_active_i%0d", idx), 32'(miso_oe[idx]), 1);
    check($sformatf("tx_ready_busy_i%0d", idx), 32'(tx_ready[idx]), 0);
    for (int i = 0; i < total; i++) begin
      if (do_rst && i == nbits) begin
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(2);
        for (int j = 0; j < 5; j++) begin
          last_rx[j]  = '0;
          buf_full[j] = 1'b0;
        end
        check("midrst_miso", 32'(miso[idx]), 0);
        check("midrst_miso_oe", 32'(miso_oe[idx]), 0);
        check_fields("midrst", idx);
      end
      b = frame[23 - i];
      if (cpha == 0) begin
        mosi = b;
        wait_cyc(HALF);
        got  = {got[22:0], miso[idx]};
        sclk = ~sclk;
        wait_cyc(HALF);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = b;
        wait_cyc(HALF);
        got  = {got[22:0], miso[idx]};
        sclk = ~sclk;
        wait_cyc(HALF);
      end
    end
    wait_cyc(HALF);
    repeat (extra) begin
      mosi = 1'($urandom);
      sclk = ~sclk;
      wait_cyc(HALF);
      sclk = ~sclk;
      wait_cyc(HALF);
    end
    cs_n[idx] = 1'b1;
    wait_cyc(2 * HALF);
    check($sformatf("miso_after_cs_i%0d", idx), 32'(miso[idx]), 0);
    check($sformatf("miso_oe_after_cs_i%0d", idx), 32'(miso_oe[idx]), 0);
  endtask

  task automatic run_frame(input int idx, input logic [23:0] frame, input bit load,
                           input logic [23:0] txd, input int nbits, input int extra);
    int v0, a0, u0;
    logic [23:0] got, exp_miso;
    logic full_at_start;
    if (load) load_tx(idx, txd);
    v0 = n_valid[idx];
    a0 = n_abort[idx];
    u0 = n_under[idx];
    full_at_start = buf_full[idx];
    exp_miso      = full_at_start ? buf_val[idx] : 24'h0;
    buf_full[idx] = 1'b0;
    xfer(idx, frame, nbits, extra, 1'b0, got);
    if (nbits == 24) last_rx[idx] = frame;
    check($sformatf("miso_stream_i%0d_n%0d", idx, nbits), 32'(got), 32'(exp_miso >> (24 - nbits)));
    check($sformatf("rx_valid_cnt_i%0d", idx), n_valid[idx] - v0, (nbits == 24) ? 1 : 0);
    check($sformatf("rx_abort_cnt_i%0d", idx), n_abort[idx] - a0, (nbits < 24) ? 1 : 0);
    check($sformatf("underrun_cnt_i%0d", idx), n_under[idx] - u0, full_at_start ? 0 : 1);
    check_fields("fields", idx);
    check($sformatf("tx_ready_idle_i%0d", idx), 32'(tx_ready[idx]), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] got;
    int v0, a0, u0, idx, nb, ld, ex;
    rst_n    = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    cs_n     = '1;
    tx_valid = '0;
    tx_data  = '0;
    for (int i = 0; i < 5; i++) begin
      last_rx[i]  = '0;
      buf_full[i] = 1'b0;
      buf_val[i]  = '0;
    end
    wait_cyc(5);
    check("rst_miso", 32'(miso), 0);
    check("rst_miso_oe", 32'(miso_oe), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_abort", 32'(rx_abort), 0);
    check("rst_underrun", 32'(tx_underrun), 0);
    for (int i = 0; i < 5; i++) check_fields("rst", i);
    rst_n = 1'b1;
    wait_cyc(3);
    check("idle_tx_ready", 32'(tx_ready), 32'h1f);

    // Same frame and response in every mode.
    for (int m = 0; m < 4; m++) run_frame(m, 24'h01_02_80, 1'b1, 24'hA5_3C_0F, 24, 0);

    // Abort after 13 bits, then a clean frame.
    run_frame(0, 24'($urandom), 1'b1, 24'($urandom), 13, 0);
    run_frame(0, 24'($urandom), 1'b1, 24'($urandom), 24, 0);

    // Underrun.
    run_frame(0, 24'hFF_FF_FF, 1'b0, 24'h0, 24, 0);

    // Narrow fields with trailing sclk clocks in the hold window.
    run_frame(4, 24'h7_3_BEEF, 1'b1, 24'($urandom), 24, 8);

    // Reset mid-frame after 10 bits.
    load_tx(0, 24'($urandom));
    buf_full[0] = 1'b0;
    v0 = n_valid[0];
    a0 = n_abort[0];
    u0 = n_under[0];
    xfer(0, 24'hC3_3C_5A, 10, 0, 1'b1, got);
    check("midrst_rx_valid_cnt", n_valid[0] - v0, 0);
    check("midrst_rx_abort_cnt", n_abort[0] - a0, 0);
    check("midrst_underrun_cnt", n_under[0] - u0, 0);
    for (int i = 0; i < 5; i++) check_fields("postrst", i);
    run_frame(0, 24'($urandom), 1'b1, 24'($urandom), 24, 0);

    // Randomised frames across all instances.
    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, 4);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : 24;
      ld  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ex  = (nb == 24) ? $urandom_range(0, 3) : 0;
      run_frame(idx, 24'($urandom), ld[0], 24'($urandom), nb, ex);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
